// File: rtl/uart_pkg.sv
// Shared definitions for the 8N1 UART: control/status bit positions, frame states, baud helpers.
package uart_pkg;

    localparam int unsigned CON_EN    = 0;
    localparam int unsigned CON_TXIE  = 1;
    localparam int unsigned CON_RXIE  = 2;
    localparam int unsigned CON_TXPND = 8;
    localparam int unsigned CON_RXPND = 9;
    localparam int unsigned CON_FERR  = 10;

    localparam logic [15:0] BAUD_RST_DEFAULT = 16'h0003;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } frame_state_e;

    // Terminal count of the per-bit counter; the bit period is this value plus one.
    function automatic logic [15:0] bit_limit(input logic [15:0] baud);
        return (baud == 16'd0) ? 16'd1 : baud;
    endfunction

endpackage

// File: rtl/uart_rx_engine.sv
// Receive side: two-flop synchroniser, start-bit qualification and mid-bit sampling.
module uart_rx_engine
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 en_i,
    input  logic                 rx_i,
    input  logic [15:0]          baud_i,
    output logic [DATA_BITS-1:0] data_o,
    output logic                 valid_o,
    output logic                 ferr_o
);

    localparam int unsigned IW = $clog2(DATA_BITS);

    frame_state_e         state_q, state_d;
    logic                 s1_q, s2_q, prev_q;
    logic [15:0]          cnt_q, cnt_d;
    logic [15:0]          lim_q, lim_d;
    logic [15:0]          half;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q, ferr_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_q    <= 1'b1;
            s2_q    <= 1'b1;
            prev_q  <= 1'b1;
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            lim_q   <= '0;
            shift_q <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            s1_q    <= rx_i;
            s2_q    <= s1_q;
            prev_q  <= s2_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lim_q   <= lim_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    // Edge is seen one cycle into the start bit, so the mid-bit check is P/2-1 counts later.
    assign half = (lim_q >> 1) + {15'd0, lim_q[0]} - 16'd1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lim_d   = lim_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        if (!en_i) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            idx_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (prev_q && !s2_q) begin
                        state_d = ST_START;
                        cnt_d   = '0;
                        lim_d   = bit_limit(baud_i);
                    end
                end
                ST_START: begin
                    if (cnt_q == half) begin
                        cnt_d = '0;
                        lim_d = bit_limit(baud_i);
                        idx_d = '0;
                        state_d = s2_q ? ST_IDLE : ST_DATA;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
                ST_DATA: begin
                    if (cnt_q == lim_q) begin
                        cnt_d   = '0;
                        lim_d   = bit_limit(baud_i);
                        shift_d = {s2_q, shift_q[DATA_BITS-1:1]};
                        if (idx_q == IW'(DATA_BITS - 1)) begin
                            state_d = ST_STOP;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
                default: begin
                    if (cnt_q == lim_q) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                        valid_d = s2_q;
                        ferr_d  = ~s2_q;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
            endcase
        end
    end

    assign data_o  = shift_q;
    assign valid_o = valid_q;
    assign ferr_o  = ferr_q;

endmodule

// File: rtl/uart_tx_engine.sv
// Transmit side: baud counter, shift register and start/data/stop sequencer.
module uart_tx_engine
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 en_i,
    input  logic                 start_i,
    input  logic [DATA_BITS-1:0] data_i,
    input  logic [15:0]          baud_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 tx_o
);

    localparam int unsigned IW = $clog2(DATA_BITS);

    frame_state_e         state_q, state_d;
    logic [15:0]          cnt_q, cnt_d;
    logic [15:0]          lim_q, lim_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic                 tx_q, tx_d;
    logic                 done_q, done_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            lim_q   <= '0;
            shift_q <= '0;
            idx_q   <= '0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lim_q   <= lim_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
        end
    end

    // The period is re-latched at every bit boundary so baud writes never split a bit.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lim_d   = lim_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        tx_d    = tx_q;
        done_d  = 1'b0;
        if (!en_i) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            idx_d   = '0;
            tx_d    = 1'b1;
        end else if (state_q == ST_IDLE) begin
            if (start_i) begin
                state_d = ST_START;
                shift_d = data_i;
                cnt_d   = '0;
                idx_d   = '0;
                lim_d   = bit_limit(baud_i);
                tx_d    = 1'b0;
            end
        end else if (cnt_q == lim_q) begin
            cnt_d = '0;
            lim_d = bit_limit(baud_i);
            case (state_q)
                ST_START: begin
                    state_d = ST_DATA;
                    tx_d    = shift_q[0];
                end
                ST_DATA: begin
                    if (idx_q == IW'(DATA_BITS - 1)) begin
                        state_d = ST_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        shift_d = shift_q >> 1;
                        tx_d    = shift_q[1];
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            endcase
        end else begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    assign busy_o = (state_q != ST_IDLE);
    assign done_o = done_q;
    assign tx_o   = tx_q | ~en_i;

endmodule

// File: rtl/uart_top_core.sv
// Register-mapped 8N1 UART: control/baud/TX buffer registers, status flags and interrupt.
module uart_top_core
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS = 8,
    parameter logic [15:0] BAUD_RST  = BAUD_RST_DEFAULT
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        uart_con_wr,
    input  logic        uart_baud_wr,
    input  logic        uart_txbuf_wr,
    input  logic [15:0] icb_wdat,
    input  logic        uart_rx,
    output logic [15:0] uart_con,
    output logic [15:0] uart_baud,
    output logic [15:0] uart_txbuf,
    output logic [15:0] uart_rxbuf,
    output logic        uart_tx,
    output logic        uart_en,
    output logic        uart_int
);

    logic [2:0]           ctl_q, ctl_d;
    logic                 txpnd_q, txpnd_d;
    logic                 rxpnd_q, rxpnd_d;
    logic                 ferr_q, ferr_d;
    logic [15:0]          baud_q, baud_d;
    logic [DATA_BITS-1:0] txbuf_q, txbuf_d;
    logic [DATA_BITS-1:0] rxbuf_q, rxbuf_d;
    logic                 int_q, int_d;
    logic [15:0]          clr;
    logic                 tx_start, tx_busy, tx_done;
    logic                 rx_valid, rx_ferr;
    logic [DATA_BITS-1:0] rx_data;

    assign tx_start = uart_txbuf_wr & ctl_q[CON_EN] & ~tx_busy;

    uart_tx_engine #(.DATA_BITS(DATA_BITS)) u_tx (
        .clk_i   (sys_clk),
        .rst_i   (sys_rst),
        .en_i    (ctl_q[CON_EN]),
        .start_i (tx_start),
        .data_i  (icb_wdat[DATA_BITS-1:0]),
        .baud_i  (baud_q),
        .busy_o  (tx_busy),
        .done_o  (tx_done),
        .tx_o    (uart_tx)
    );

    uart_rx_engine #(.DATA_BITS(DATA_BITS)) u_rx (
        .clk_i   (sys_clk),
        .rst_i   (sys_rst),
        .en_i    (ctl_q[CON_EN]),
        .rx_i    (uart_rx),
        .baud_i  (baud_q),
        .data_o  (rx_data),
        .valid_o (rx_valid),
        .ferr_o  (rx_ferr)
    );

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            ctl_q   <= '0;
            txpnd_q <= 1'b0;
            rxpnd_q <= 1'b0;
            ferr_q  <= 1'b0;
            baud_q  <= BAUD_RST;
            txbuf_q <= '0;
            rxbuf_q <= '0;
            int_q   <= 1'b0;
        end else begin
            ctl_q   <= ctl_d;
            txpnd_q <= txpnd_d;
            rxpnd_q <= rxpnd_d;
            ferr_q  <= ferr_d;
            baud_q  <= baud_d;
            txbuf_q <= txbuf_d;
            rxbuf_q <= rxbuf_d;
            int_q   <= int_d;
        end
    end

    // Hardware set is OR-ed after the write-1-to-clear mask so a coincident set wins.
    always_comb begin
        ctl_d   = uart_con_wr ? icb_wdat[2:0] : ctl_q;
        baud_d  = uart_baud_wr ? icb_wdat : baud_q;
        txbuf_d = tx_start ? icb_wdat[DATA_BITS-1:0] : txbuf_q;
        rxbuf_d = rx_valid ? rx_data : rxbuf_q;
        clr     = uart_con_wr ? icb_wdat : '0;
        txpnd_d = tx_done  | (txpnd_q & ~clr[CON_TXPND]);
        rxpnd_d = rx_valid | (rxpnd_q & ~clr[CON_RXPND]);
        ferr_d  = rx_ferr  | (ferr_q  & ~clr[CON_FERR]);
        int_d   = (txpnd_q & ctl_q[CON_TXIE]) | ((rxpnd_q | ferr_q) & ctl_q[CON_RXIE]);
    end

    always_comb begin
        uart_con            = '0;
        uart_con[2:0]       = ctl_q;
        uart_con[CON_TXPND] = txpnd_q;
        uart_con[CON_RXPND] = rxpnd_q;
        uart_con[CON_FERR]  = ferr_q;
    end

    assign uart_baud  = baud_q;
    assign uart_txbuf = {{(16 - DATA_BITS){1'b0}}, txbuf_q};
    assign uart_rxbuf = {{(16 - DATA_BITS){1'b0}}, rxbuf_q};
    assign uart_en    = ctl_q[CON_EN];
    assign uart_int   = int_q;

endmodule

// File: tb/tb_uart_top_core.sv
// Self-checking bench for uart_top_core: register behaviour, TX waveform, loopback and framing errors.
module tb_uart_top_core;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic        uart_con_wr, uart_baud_wr, uart_txbuf_wr;
    logic [15:0] icb_wdat;
    logic        rx_drv, loop_en, rx_line;
    logic [15:0] uart_con, uart_baud, uart_txbuf, uart_rxbuf;
    logic        uart_tx, uart_en, uart_int;

    int unsigned vectors = 0;
    int unsigned errors  = 0;
    logic        exp_bits[$];
    logic [15:0] exp_words[$];

    always #5 sys_clk = ~sys_clk;

    assign rx_line = loop_en ? uart_tx : rx_drv;

    uart_top_core #(.DATA_BITS(8), .BAUD_RST(16'h0003)) dut (
        .sys_clk       (sys_clk),
        .sys_rst       (sys_rst),
        .uart_con_wr   (uart_con_wr),
        .uart_baud_wr  (uart_baud_wr),
        .uart_txbuf_wr (uart_txbuf_wr),
        .icb_wdat      (icb_wdat),
        .uart_rx       (rx_line),
        .uart_con      (uart_con),
        .uart_baud     (uart_baud),
        .uart_txbuf    (uart_txbuf),
        .uart_rxbuf    (uart_rxbuf),
        .uart_tx       (uart_tx),
        .uart_en       (uart_en),
        .uart_int      (uart_int)
    );

    // Called at a falling edge; the strobe is seen by the next rising edge and the task returns at the following falling edge.
    task automatic bus_write(input int unsigned sel, input logic [15:0] d);
        uart_con_wr   = (sel == 0);
        uart_baud_wr  = (sel == 1);
        uart_txbuf_wr = (sel == 2);
        icb_wdat      = d;
        @(negedge sys_clk);
        uart_con_wr   = 1'b0;
        uart_baud_wr  = 1'b0;
        uart_txbuf_wr = 1'b0;
    endtask

    task automatic push_frame(input logic [7:0] b, input int unsigned p);
        logic [9:0] fr;
        fr = {1'b1, b, 1'b0};
        for (int i = 0; i < 10; i++)
            for (int k = 0; k < int'(p); k++) exp_bits.push_back(fr[i]);
    endtask

    task automatic drive_frame(input logic [7:0] b, input logic stop, input int unsigned p);
        rx_drv = 1'b0;
        repeat (p) @(negedge sys_clk);
        for (int i = 0; i < 8; i++) begin
            rx_drv = b[i];
            repeat (p) @(negedge sys_clk);
        end
        rx_drv = stop;
        repeat (p) @(negedge sys_clk);
        rx_drv = 1'b1;
        repeat (2 * p) @(negedge sys_clk);
    endtask

    task automatic wait_con_bit(input int unsigned bitpos, input string name);
        int n;
        n = 0;
        while (uart_con[bitpos] !== 1'b1 && n < 300) begin
            @(negedge sys_clk);
            n++;
        end
        vectors++;
        if (uart_con[bitpos] !== 1'b1) begin
            errors++;
            $display("FAIL %s timeout: uart_con=%h, bit %0d never set", name, uart_con, bitpos);
        end
    endtask

    task automatic test_reset;
        sys_rst = 1'b1; uart_con_wr = 0; uart_baud_wr = 0; uart_txbuf_wr = 0;
        icb_wdat = '0; rx_drv = 1'b1; loop_en = 1'b0;
        repeat (3) @(negedge sys_clk);
        sys_rst = 1'b0;
        @(negedge sys_clk);
        bus_write(0, 16'h0007);
        bus_write(1, 16'h0009);
        bus_write(2, 16'h0012);
        repeat (3) @(negedge sys_clk);
        #2 sys_rst = 1'b1;
        #1;
        vectors++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL rst_tx: got %b want 1", uart_tx); end
        vectors++; if (uart_con !== 16'h0000) begin errors++; $display("FAIL rst_con: got %h want 0000", uart_con); end
        vectors++; if (uart_baud !== 16'h0003) begin errors++; $display("FAIL rst_baud: got %h want 0003", uart_baud); end
        vectors++; if (uart_txbuf !== 16'h0000) begin errors++; $display("FAIL rst_txbuf: got %h want 0000", uart_txbuf); end
        vectors++; if (uart_int !== 1'b0 || uart_en !== 1'b0) begin errors++; $display("FAIL rst_int_en: got int=%b en=%b want 0 0", uart_int, uart_en); end
        @(negedge sys_clk);
        sys_rst = 1'b0;
        @(negedge sys_clk);
        vectors++; if (uart_rxbuf !== 16'h0000) begin errors++; $display("FAIL rst_rxbuf: got %h want 0000", uart_rxbuf); end
    endtask

    task automatic test_transmit;
        logic e;
        bus_write(1, 16'h0003);
        bus_write(0, 16'h0001);
        push_frame(8'h3A, 4);
        bus_write(2, 16'h003A);
        for (int i = 0; i < 40; i++) begin
            e = exp_bits.pop_front();
            vectors++;
            if (uart_tx !== e) begin errors++; $display("FAIL tx_bit cycle %0d: got %b want %b", i, uart_tx, e); end
            @(negedge sys_clk);
        end
        vectors++; if (uart_con[8] !== 1'b0) begin errors++; $display("FAIL txpnd_early: got %b want 0", uart_con[8]); end
        @(negedge sys_clk);
        vectors++; if (uart_con[8] !== 1'b1) begin errors++; $display("FAIL txpnd_41: got %b want 1", uart_con[8]); end
        vectors++; if (uart_txbuf !== 16'h003A) begin errors++; $display("FAIL txbuf_3a: got %h want 003a", uart_txbuf); end
        vectors++; if (uart_en !== 1'b1) begin errors++; $display("FAIL en: got %b want 1", uart_en); end
    endtask

    task automatic test_tx_irq;
        bus_write(0, 16'h0103);
        repeat (2) @(negedge sys_clk);
        vectors++; if (uart_con !== 16'h0003 || uart_int !== 1'b0) begin errors++; $display("FAIL irq_pre: got con=%h int=%b want 0003 0", uart_con, uart_int); end
        bus_write(2, 16'h0055);
        wait_con_bit(8, "irq_txpnd");
        vectors++; if (uart_int !== 1'b0) begin errors++; $display("FAIL irq_lag: got %b want 0", uart_int); end
        @(negedge sys_clk);
        vectors++; if (uart_int !== 1'b1) begin errors++; $display("FAIL irq_set: got %b want 1", uart_int); end
        bus_write(0, 16'h0103);
        vectors++; if (uart_con[8] !== 1'b0 || uart_int !== 1'b1) begin errors++; $display("FAIL irq_clr0: got pnd=%b int=%b want 0 1", uart_con[8], uart_int); end
        @(negedge sys_clk);
        vectors++; if (uart_int !== 1'b0) begin errors++; $display("FAIL irq_drop: got %b want 0", uart_int); end
    endtask

    task automatic test_busy_disabled;
        logic saw_low;
        bus_write(0, 16'h0101);
        bus_write(2, 16'h0011);
        repeat (5) @(negedge sys_clk);
        bus_write(2, 16'h00A5);
        vectors++; if (uart_txbuf !== 16'h0011) begin errors++; $display("FAIL busy_txbuf: got %h want 0011", uart_txbuf); end
        wait_con_bit(8, "busy_done");
        vectors++; if (uart_txbuf !== 16'h0011) begin errors++; $display("FAIL busy_txbuf_end: got %h want 0011", uart_txbuf); end
        bus_write(2, 16'h0000);
        repeat (6) @(negedge sys_clk);
        vectors++; if (uart_tx !== 1'b0) begin errors++; $display("FAIL abort_pre: got %b want 0", uart_tx); end
        bus_write(0, 16'h0000);
        vectors++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL abort_tx: got %b want 1", uart_tx); end
        vectors++; if (uart_con !== 16'h0100) begin errors++; $display("FAIL abort_flags: got %h want 0100", uart_con); end
        bus_write(0, 16'h0100);
        bus_write(2, 16'h0077);
        saw_low = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (uart_tx !== 1'b1) saw_low = 1'b1;
            @(negedge sys_clk);
        end
        vectors++; if (saw_low !== 1'b0) begin errors++; $display("FAIL dis_line: got low pulse, want idle high"); end
        vectors++; if (uart_con !== 16'h0000) begin errors++; $display("FAIL dis_con: got %h want 0000", uart_con); end
        vectors++; if (uart_txbuf !== 16'h0000) begin errors++; $display("FAIL dis_txbuf: got %h want 0000", uart_txbuf); end
    endtask

    task automatic test_loopback;
        logic [15:0] w;
        loop_en = 1'b1;
        bus_write(0, 16'h0705);
        exp_words.push_back(16'h00C3);
        bus_write(2, 16'h00C3);
        wait_con_bit(9, "loop_rxpnd");
        w = exp_words.pop_front();
        vectors++; if (uart_rxbuf !== w) begin errors++; $display("FAIL loop_rxbuf: got %h want %h", uart_rxbuf, w); end
        vectors++; if (uart_con[10] !== 1'b0) begin errors++; $display("FAIL loop_ferr: got %b want 0", uart_con[10]); end
        @(negedge sys_clk);
        vectors++; if (uart_int !== 1'b1) begin errors++; $display("FAIL loop_int: got %b want 1", uart_int); end
        wait_con_bit(8, "loop_txdone");
        loop_en = 1'b0;
        repeat (4) @(negedge sys_clk);
    endtask

    task automatic test_framing_error;
        bus_write(0, 16'h0705);
        drive_frame(8'h5A, 1'b0, 4);
        wait_con_bit(10, "ferr_set");
        vectors++; if (uart_con[9] !== 1'b0) begin errors++; $display("FAIL ferr_rxpnd: got %b want 0", uart_con[9]); end
        vectors++; if (uart_rxbuf !== 16'h00C3) begin errors++; $display("FAIL ferr_rxbuf: got %h want 00c3", uart_rxbuf); end
    endtask

    task automatic test_baud_zero;
        logic        e;
        logic [15:0] w;
        bus_write(1, 16'h0000);
        bus_write(0, 16'h0701);
        vectors++; if (uart_baud !== 16'h0000) begin errors++; $display("FAIL baud0_rd: got %h want 0000", uart_baud); end
        push_frame(8'hF0, 2);
        bus_write(2, 16'h00F0);
        for (int i = 0; i < 20; i++) begin
            e = exp_bits.pop_front();
            vectors++;
            if (uart_tx !== e) begin errors++; $display("FAIL tx_b0 cycle %0d: got %b want %b", i, uart_tx, e); end
            @(negedge sys_clk);
        end
        wait_con_bit(8, "b0_txdone");
        bus_write(0, 16'h0705);
        exp_words.push_back(16'h0096);
        drive_frame(8'h96, 1'b1, 2);
        wait_con_bit(9, "b0_rxpnd");
        w = exp_words.pop_front();
        vectors++; if (uart_rxbuf !== w) begin errors++; $display("FAIL b0_rxbuf: got %h want %h", uart_rxbuf, w); end
        vectors++; if (uart_con[10] !== 1'b0) begin errors++; $display("FAIL b0_ferr: got %b want 0", uart_con[10]); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_transmit();
        test_tx_irq();
        test_busy_disabled();
        test_loopback();
        test_framing_error();
        test_baud_zero();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
